// File: rtl/timer_entrada_param_if.sv
// Keypad/control inputs and BCD display outputs of the countdown timer.
// The master side drives keys and controls; the slave side is the timer.
interface timer_entrada_param_if #(
    parameter int NDIG = 4
);
    logic [9:0]        keypad;
    logic              startn;
    logic              stopn;
    logic              clearn;
    logic [4*NDIG-1:0] digits;
    logic              running;
    logic              pgt_1Hz;
    logic              done;
    logic              zero;

    modport master (
        output keypad, startn, stopn, clearn,
        input  digits, running, pgt_1Hz, done, zero
    );

    modport slave (
        input  keypad, startn, stopn, clearn,
        output digits, running, pgt_1Hz, done, zero
    );
endinterface

// File: rtl/timer_entrada_param.sv
// Keypad-entry MM..SS countdown timer with start/stop/clear and terminal-count pulse.
// Latency: outputs move two clk100 edges after an input change (register + edge detect).
// No backpressure: inputs are levels, every detected event is acted on immediately.
module timer_entrada_param #(
    parameter int DIV  = 100,
    parameter int NDIG = 4
) (
    input  logic                  clk100,
    input  logic                  resetn,
    timer_entrada_param_if.slave  tif
);
    localparam int W  = 4 * NDIG;
    localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUNNING,
        ST_PAUSED,
        ST_DONE
    } state_t;

    state_t          state;
    logic [W-1:0]    digit_q;
    logic [DW-1:0]   div_q;
    logic            running_q;
    logic            pgt_q;
    logic            done_q;

    logic [9:0]      key_q, key_p;
    logic            startn_q, startn_p;
    logic            stopn_q, stopn_p;
    logic            clearn_q, clearn_p;

    logic            key_ev, start_ev, stop_ev, clr_ev;
    logic            start_act, key_act;
    logic [W-1:0]    shifted;
    logic [W-1:0]    decremented;

    function automatic logic [3:0] key_code(input logic [9:0] k);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 10; i++) begin
            if (k[i]) c = 4'(i);
        end
        return c;
    endfunction

    // Digit 1 is seconds tens and wraps to 5; every other digit wraps to 9.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = (i == 1) ? 4'd5 : 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        key_ev      = (key_p == 10'd0) && (key_q != 10'd0);
        start_ev    = startn_p && !startn_q;
        stop_ev     = stopn_p  && !stopn_q;
        clr_ev      = clearn_p && !clearn_q;
        start_act   = start_ev && !stop_ev;
        key_act     = key_ev && !stop_ev && !start_ev;
        shifted     = {digit_q[W-5:0], key_code(key_q)};
        decremented = bcd_dec(digit_q);
    end

    always_ff @(posedge clk100) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            digit_q   <= '0;
            div_q     <= '0;
            running_q <= 1'b0;
            pgt_q     <= 1'b0;
            done_q    <= 1'b0;
            key_q     <= '0;
            key_p     <= '0;
            startn_q  <= 1'b0;
            startn_p  <= 1'b0;
            stopn_q   <= 1'b0;
            stopn_p   <= 1'b0;
            clearn_q  <= 1'b0;
            clearn_p  <= 1'b0;
        end else begin
            key_q    <= tif.keypad;
            key_p    <= key_q;
            startn_q <= tif.startn;
            startn_p <= startn_q;
            stopn_q  <= tif.stopn;
            stopn_p  <= stopn_q;
            clearn_q <= tif.clearn;
            clearn_p <= clearn_q;
            pgt_q    <= 1'b0;
            done_q   <= 1'b0;

            if (clr_ev) begin
                state     <= ST_IDLE;
                digit_q   <= '0;
                div_q     <= '0;
                running_q <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_act && (digit_q != '0)) begin
                            state     <= ST_RUNNING;
                            div_q     <= '0;
                            running_q <= 1'b1;
                        end else if (key_act) begin
                            digit_q <= shifted;
                        end
                    end
                    ST_RUNNING: begin
                        if (stop_ev) begin
                            state     <= ST_PAUSED;
                            running_q <= 1'b0;
                        end else if (div_q == DW'(DIV - 1)) begin
                            div_q   <= '0;
                            pgt_q   <= 1'b1;
                            digit_q <= decremented;
                            if (decremented == '0) begin
                                done_q    <= 1'b1;
                                state     <= ST_DONE;
                                running_q <= 1'b0;
                            end
                        end else begin
                            div_q <= div_q + DW'(1);
                        end
                    end
                    ST_PAUSED: begin
                        // Divider keeps its phase so the resumed second is not stretched.
                        if (start_act) begin
                            state     <= ST_RUNNING;
                            running_q <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        if (key_act) begin
                            state   <= ST_IDLE;
                            digit_q <= shifted;
                        end
                    end
                    default: begin
                        state     <= ST_IDLE;
                        running_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tif.digits  = digit_q;
    assign tif.running = running_q;
    assign tif.pgt_1Hz = pgt_q;
    assign tif.done    = done_q;
    assign tif.zero    = (digit_q == '0);
endmodule

// File: tb/tb_timer_entrada_param.sv
// Directed and randomized bench for timer_entrada_param against a decimal-arithmetic model.
module tb_timer_entrada_param;
    localparam int DIV  = 4;
    localparam int NDIG = 4;
    localparam int W    = 4 * NDIG;
    localparam int MOD  = 10 ** NDIG;

    logic clk100 = 1'b0;
    logic resetn = 1'b0;

    timer_entrada_param_if #(.NDIG(NDIG)) tif ();

    timer_entrada_param #(.DIV(DIV), .NDIG(NDIG)) dut (
        .clk100 (clk100),
        .resetn (resetn),
        .tif    (tif.slave)
    );

    always #5 clk100 = ~clk100;

    int n_tests  = 0;
    int n_fail   = 0;
    int pgt_cnt  = 0;
    int done_cnt = 0;

    // Reference model: the display value as one decimal number.
    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mst_t;
    mst_t       m_st  = M_IDLE;
    int         m_val = 0;
    int         m_div = 0;
    bit         m_pgt = 1'b0;
    bit         m_done = 1'b0;
    logic [9:0] hk_cur = '0, hk_prev = '0;
    bit         hs_cur = 0, hs_prev = 0, hp_cur = 0, hp_prev = 0, hc_cur = 0, hc_prev = 0;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic model_edge(input bit rn, input logic [9:0] k, input bit s, input bit p, input bit c);
        bit ev_key, ev_start, ev_stop, ev_clr;
        int code, mins, secs;
        if (!rn) begin
            m_st = M_IDLE; m_val = 0; m_div = 0; m_pgt = 0; m_done = 0;
            hk_cur = '0; hk_prev = '0;
            hs_cur = 0; hs_prev = 0; hp_cur = 0; hp_prev = 0; hc_cur = 0; hc_prev = 0;
            return;
        end
        ev_key   = (hk_prev == 10'd0) && (hk_cur != 10'd0);
        ev_start = hs_prev && !hs_cur;
        ev_stop  = hp_prev && !hp_cur;
        ev_clr   = hc_prev && !hc_cur;
        code = 0;
        for (int i = 0; i < 10; i++) if (hk_cur[i]) code = i;
        m_pgt = 0;
        m_done = 0;
        if (ev_clr) begin
            m_val = 0; m_div = 0; m_st = M_IDLE;
        end else if (ev_stop) begin
            if (m_st == M_RUN) m_st = M_PAUSE;
        end else if (m_st == M_RUN) begin
            if (m_div == DIV - 1) begin
                m_div = 0;
                m_pgt = 1;
                mins = m_val / 100;
                secs = m_val % 100;
                if (secs > 0) secs--; else begin secs = 59; mins--; end
                m_val = mins * 100 + secs;
                if (m_val == 0) begin m_done = 1; m_st = M_DONE; end
            end else begin
                m_div++;
            end
        end else if (ev_start) begin
            if (m_st == M_IDLE && m_val != 0) begin m_st = M_RUN; m_div = 0; end
            else if (m_st == M_PAUSE) m_st = M_RUN;
        end else if (ev_key && (m_st == M_IDLE || m_st == M_DONE)) begin
            m_val = (m_val * 10 + code) % MOD;
            m_st  = M_IDLE;
        end
        hk_prev = hk_cur; hk_cur = k;
        hs_prev = hs_cur; hs_cur = s;
        hp_prev = hp_cur; hp_cur = p;
        hc_prev = hc_cur; hc_cur = c;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rn, input logic [9:0] k, input bit s, input bit p, input bit c);
        resetn     = rn;
        tif.keypad = k;
        tif.startn = s;
        tif.stopn  = p;
        tif.clearn = c;
        @(posedge clk100);
        model_edge(rn, k, s, p, c);
        #1;
        if (tif.pgt_1Hz === 1'b1) pgt_cnt++;
        if (tif.done === 1'b1) done_cnt++;
        chk("model_digits",  32'(tif.digits),  32'(to_bcd(m_val)));
        chk("model_running", 32'(tif.running), 32'(m_st == M_RUN));
        chk("model_pgt",     32'(tif.pgt_1Hz), 32'(m_pgt));
        chk("model_done",    32'(tif.done),    32'(m_done));
        chk("model_zero",    32'(tif.zero),    32'(m_val == 0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 10'd0, 1, 1, 1);
    endtask

    task automatic press(input int k);
        step(1, 10'(1 << k), 1, 1, 1);
        idle(3);
    endtask

    task automatic start_pulse();
        step(1, 10'd0, 0, 1, 1);
    endtask

    task automatic clear_all();
        step(1, 10'd0, 1, 1, 0);
        idle(2);
    endtask

    initial begin
        tif.keypad = '0;
        tif.startn = 1'b1;
        tif.stopn  = 1'b1;
        tif.clearn = 1'b1;
        step(0, 10'd0, 1, 1, 1);
        step(0, 10'd0, 1, 1, 1);
        chk("reset_digits",  32'(tif.digits),  32'h0);
        chk("reset_running", 32'(tif.running), 32'h0);
        chk("reset_zero",    32'(tif.zero),    32'h1);
        chk("reset_done",    32'(tif.done),    32'h0);
        idle(2);

        // Entry with priority shifting
        press(1); press(2); press(3); press(4); press(5);
        chk("entry_digits",  32'(tif.digits),  32'h2345);
        chk("entry_running", 32'(tif.running), 32'h0);

        clear_all();
        for (int i = 0; i < 10; i++) step(1, 10'(1 << 7), 1, 1, 1);
        idle(3);
        chk("hold_one_shift", 32'(tif.digits), 32'h0007);

        // Countdown with minute borrow
        clear_all();
        press(1); press(0); press(0);
        start_pulse();
        pgt_cnt = 0;
        idle(5);
        chk("borrow_59",     32'(tif.digits), 32'h0059);
        chk("borrow_pgt",    32'(pgt_cnt),    32'd1);
        idle(4);
        chk("borrow_58",     32'(tif.digits), 32'h0058);
        idle(4);
        chk("borrow_57",     32'(tif.digits), 32'h0057);

        // Terminal count
        clear_all();
        press(2);
        start_pulse();
        idle(5);
        chk("term_01", 32'(tif.digits), 32'h0001);
        done_cnt = 0;
        idle(4);
        chk("term_00",      32'(tif.digits),  32'h0000);
        chk("term_running", 32'(tif.running), 32'h0);
        chk("term_zero",    32'(tif.zero),    32'h1);
        idle(3);
        chk("term_done_once", 32'(done_cnt), 32'd1);
        start_pulse();
        idle(3);
        chk("done_start_ignored", 32'(tif.running), 32'h0);
        press(3);
        chk("done_key_lsd", 32'(tif.digits), 32'h0003);

        // Pause holds divider phase
        clear_all();
        press(3); press(0);
        start_pulse();
        idle(2);
        step(1, 10'd0, 1, 0, 1);
        pgt_cnt = 0;
        idle(20);
        chk("pause_no_tick", 32'(pgt_cnt),     32'd0);
        chk("pause_value",   32'(tif.digits),  32'h0030);
        chk("pause_running", 32'(tif.running), 32'h0);
        start_pulse();
        idle(2);
        chk("resume_early",  32'(pgt_cnt),    32'd0);
        idle(1);
        chk("resume_tick",   32'(pgt_cnt),    32'd1);
        chk("resume_value",  32'(tif.digits), 32'h0029);

        // Priority and ignored events
        clear_all();
        step(1, 10'(1 << 3) | 10'(1 << 9), 1, 1, 1);
        idle(3);
        chk("key_priority", 32'(tif.digits), 32'h0009);
        clear_all();
        start_pulse();
        idle(3);
        chk("start_on_zero", 32'(tif.running), 32'h0);
        press(5);
        start_pulse();
        step(1, 10'(1 << 1), 1, 1, 1);
        idle(4);
        chk("key_while_run", 32'(tif.digits), 32'h0004);
        step(1, 10'd0, 0, 1, 0);
        idle(3);
        chk("clear_beats_start_val", 32'(tif.digits),  32'h0);
        chk("clear_beats_start_run", 32'(tif.running), 32'h0);

        // Entered seconds above 59 are not normalised
        press(7); press(5);
        start_pulse();
        idle(5);
        chk("sec_75", 32'(tif.digits), 32'h0074);

        // Reset while running
        clear_all();
        press(1); press(5);
        start_pulse();
        idle(3);
        done_cnt = 0;
        step(0, 10'd0, 1, 1, 1);
        chk("rst_run_digits",  32'(tif.digits),  32'h0);
        chk("rst_run_running", 32'(tif.running), 32'h0);
        chk("rst_run_zero",    32'(tif.zero),    32'h1);
        idle(3);
        chk("rst_run_no_done", 32'(done_cnt), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            logic [9:0] k;
            bit s, p, c, rn;
            int hold;
            k = ($urandom_range(0, 2) == 0) ? 10'(1 << $urandom_range(0, 9)) : 10'd0;
            if ($urandom_range(0, 9) == 0) k = 10'($urandom);
            s    = ($urandom_range(0, 4) != 0);
            p    = ($urandom_range(0, 9) != 0);
            c    = ($urandom_range(0, 24) != 0);
            rn   = ($urandom_range(0, 99) != 0);
            hold = $urandom_range(1, 3);
            for (int j = 0; j < hold; j++) step(rn, k, s, p, c);
            idle($urandom_range(0, 8));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/timer_entrada_param.md
Name: timer_entrada_param

Overview:
- Parametrised keypad-entry countdown timer. It generalises the keypad/encoder/divider/counter entry path to NDIG BCD digits in MM..SS format, with start/stop/clear control and a terminal-count flag.
- It sits between the 10-key keypad and the display/controle logic.
- A single clk100 domain; the divider is internal and produces the count tick.

Parameters:
- DIV, 100: clk100 cycles per count tick (1 Hz at 100 Hz clock); must be >= 2.
- NDIG, 4: number of BCD digits, even and >= 2. The low 2 digits are seconds; the upper NDIG-2 digits are minutes.

Ports:
- clk100  input  1  system clock, rising edge.
- resetn  input  1  synchronous active-low reset.
- keypad  input  10  one bit per key 0..9, active-high level.
- startn  input  1  active-low start/resume, level.
- stopn  input  1  active-low pause, level.
- clearn  input  1  active-low clear, level.
- digits  output  4*NDIG  BCD value; digit 0 (seconds units) in bits [3:0].
- running  output  1  high while in RUNNING.
- pgt_1Hz  output  1  one-cycle tick pulse, asserted only in RUNNING.
- done  output  1  one-cycle pulse when the count reaches zero.
- zero  output  1  high when digits == 0 (combinational from the digit register).

Behaviour:
- Reset: synchronous and active-low, sampled on the clk100 rising edge. It has priority over everything.
  - State IDLE; digits = 0.
  - running = 0, pgt_1Hz = 0, done = 0, zero = 1.
  - Divider counter = 0; all edge-detect registers cleared.
- Input conditioning: keypad, startn, stopn and clearn are registered once. Events are edge-detected against the previous registered sample, so holding an input never repeats it.
  - Key event: registered keypad goes from all-zero to non-zero.
  - Start, stop, clear events: falling edge of startn, stopn, clearn respectively.
- Key encoding: priority, highest index wins; e.g. keys 3 and 7 together encode 7.
- Event priority in the same cycle: clear > stop > start > key.
- Clear event, any state: digits = 0, divider = 0, next state IDLE.
- IDLE:
  - Key event: digits shift left one digit; the new digit enters digit 0 and the MSD is discarded (e.g. NDIG=4, 0012 + key 5 -> 0125).
  - Start event with digits != 0: go to RUNNING and set divider = 0.
  - Start event with digits == 0: ignored.
- RUNNING:
  - Divider counts 0..DIV-1. When it wraps (DIV-1 -> 0), pgt_1Hz = 1 for that cycle and the value decrements. The first tick occurs DIV cycles after entering RUNNING.
  - Key events are ignored.
  - Stop event: go to PAUSED; the divider holds its value.
  - Start event: no effect.
- Decrement rules:
  - Seconds units 0 -> 9 with borrow.
  - Seconds tens 0 -> 5 with borrow. Entered seconds > 59 are not normalised: 0:75 counts 0:74 ...
  - Each minute digit 0 -> 9 with borrow.
- When a decrement yields 0: done = 1 for that cycle and next state is DONE. Example: 00:01 -> tick -> 00:00 with done.
- PAUSED:
  - Start event: go to RUNNING and resume the divider from its held value.
  - Key events are ignored.
  - pgt_1Hz = 0.
- DONE:
  - digits hold 0; pgt_1Hz = 0.
  - A key event returns to IDLE and is also shifted in, so that digit becomes the LSD.
  - A start event is ignored, because the value is 0.
- Output timing: all outputs except zero are registered and update the cycle after the triggering registered event. done and pgt_1Hz never assert outside the transition cycle.
- Simultaneous clear with a final tick: clear wins; done does not pulse.
- Reset mid-count: returns to IDLE with digits 0 on the next edge.

Test Plan:
- Entry (NDIG=4, DIV=4): reset; press 1, 2, 3, 4, 5 with releases between -> digits 0x2345 and running = 0. Holding key 7 for 10 cycles -> exactly one shift.
- Countdown with borrow: enter 100, start -> after 4 cycles 0x0059 with one pgt_1Hz. After each further 4 cycles 0x0058, 0x0057, ...
- Terminal: enter 2, start -> 0x0001 at +4 cycles, then 0x0000 at +8 cycles with done high exactly one cycle. running = 0, zero = 1, state DONE. A later key 3 -> IDLE with digits 0x0003.
- Pause/resume: enter 30, start; assert stopn at divider phase 2 -> no ticks for 20 cycles. Start -> next tick 2 cycles later (phase held).
- Priority/ignore: keys 3 and 9 together -> digit 9. Start with digits 0 -> stays IDLE. Key pressed while RUNNING -> value unaffected. Start and clear in the same cycle -> IDLE with digits 0.
- Reset mid-run: resetn low while RUNNING at 0x0015 -> next edge: digits 0, running = 0, zero = 1, no done pulse.
